bmu_req_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one bit-manipulation unit (BMU) between NREQ requesters.
- Accepts one operation at a time from a requester and drives it into the BMU input bundle for exactly one cycle.
- Waits the BMU's fixed result latency, then captures result and error and returns them with the requester ID under a valid/ready handshake.
- Sits between the issue sources (e.g. pipeline lanes, a CSR-driven test engine) and the BMU.

---
 rtl/bmu_req_arb_if.sv | 34 +++
 rtl/bmu_req_arb.sv | 205 ++++++++++++++++++++
 tb/tb_bmu_req_arb.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bmu_req_arb_if.sv
// Requester/response bundle between the issue sources and the BMU arbiter.
// master: the requester side (drives requests, consumes responses).
// slave : the arbiter side.
interface bmu_req_arb_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AP_W = 32,
  parameter int unsigned IDW  = 3
) ();

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AP_W-1:0] req_ap;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [NREQ-1:0]      req_csr_ren;
  logic [NREQ*32-1:0]   req_csr_rddata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_result;
  logic                 rsp_error;

  modport master (
    output req_valid, req_ap, req_a, req_b, req_csr_ren, req_csr_rddata, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_error
  );

  modport slave (
    input  req_valid, req_ap, req_a, req_b, req_csr_ren, req_csr_rddata, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_error
  );

endinterface

// File: rtl/bmu_req_arb.sv
// Round-robin arbiter/sequencer sharing one bit-manipulation unit between
// NREQ requesters: grant, issue for one cycle, wait BMU_LAT, return result.
// Optional performance counters are enabled with the macro BMU_ARB_PERF_EN.
module bmu_req_arb #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AP_W    = 32,
  parameter int unsigned BMU_LAT = 1,
  parameter int unsigned IDW     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_scan_mode,
  bmu_req_arb_if.slave         bus,
  output logic                 o_bmu_scan_mode,
  output logic                 o_bmu_valid_in,
  output logic [AP_W-1:0]      o_bmu_ap,
  output logic                 o_bmu_csr_ren_in,
  output logic [31:0]          o_bmu_csr_rddata_in,
  output logic [31:0]          o_bmu_a_in,
  output logic [31:0]          o_bmu_b_in,
  input  logic [31:0]          i_bmu_result_ff,
  input  logic                 i_bmu_error,
  output logic [NREQ*16-1:0]   o_perf_grant_cnt,
  output logic [15:0]          o_perf_err_cnt
);

  localparam int unsigned CNT_W = (BMU_LAT < 2) ? 1 : $clog2(BMU_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_gid;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bmu_valid;
  logic [AP_W-1:0]    r_ap;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_csr_ren;
  logic [31:0]        r_csr_rddata;
  logic               r_rsp_valid;
  logic [IDW-1:0]     r_rsp_id;
  logic [31:0]        r_rsp_result;
  logic               r_rsp_error;

  logic               w_any;
  logic [IDW-1:0]     w_gnt;
  logic [NREQ-1:0]    w_req_ready;
  logic               w_req_hs;
  logic               w_rsp_hs;
  logic [AP_W-1:0]    w_sel_ap;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic               w_sel_csr_ren;
  logic [31:0]        w_sel_csr_rddata;

  // Round-robin search: first valid requester starting at r_ptr, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_any && bus.req_valid[j] &&
            (((32'(r_ptr) + 32'(k)) % NREQ) == 32'(j))) begin
          w_any = 1'b1;
          w_gnt = IDW'(j);
        end
      end
    end
  end

  // Ready is offered only to the granted requester, only in IDLE, never in reset.
  always_comb begin
    w_req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_req_ready[j] = (r_state == S_IDLE) && !rst && w_any && (w_gnt == IDW'(j));
    end
  end

  // Operand slice of the granted requester.
  always_comb begin
    w_sel_ap         = '0;
    w_sel_a          = '0;
    w_sel_b          = '0;
    w_sel_csr_ren    = 1'b0;
    w_sel_csr_rddata = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_gnt == IDW'(j)) begin
        w_sel_ap         = bus.req_ap[j*AP_W +: AP_W];
        w_sel_a          = bus.req_a[j*32 +: 32];
        w_sel_b          = bus.req_b[j*32 +: 32];
        w_sel_csr_ren    = bus.req_csr_ren[j];
        w_sel_csr_rddata = bus.req_csr_rddata[j*32 +: 32];
      end
    end
  end

  assign w_req_hs = (r_state == S_IDLE) && w_any;
  assign w_rsp_hs = (r_state == S_RESP) && bus.rsp_ready;

  // Sequencer: grant, one-cycle issue, latency wait, response hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_gid        <= '0;
      r_cnt        <= '0;
      r_bmu_valid  <= 1'b0;
      r_ap         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_csr_ren    <= 1'b0;
      r_csr_rddata <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_ap         <= w_sel_ap;
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            r_csr_ren    <= w_sel_csr_ren;
            r_csr_rddata <= w_sel_csr_rddata;
            r_gid        <= w_gnt;
            r_bmu_valid  <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_bmu_valid <= 1'b0;
          r_cnt       <= CNT_W'(BMU_LAT);
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_rsp_result <= i_bmu_result_ff;
            r_rsp_error  <= i_bmu_error;
            r_rsp_id     <= r_gid;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_gid == IDW'(NREQ - 1)) ? '0 : r_gid + IDW'(1);
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_bmu_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready        = w_req_ready;
  assign bus.rsp_valid        = r_rsp_valid;
  assign bus.rsp_id           = r_rsp_id;
  assign bus.rsp_result       = r_rsp_result;
  assign bus.rsp_error        = r_rsp_error;

  assign o_bmu_scan_mode      = i_scan_mode;
  assign o_bmu_valid_in       = r_bmu_valid;
  assign o_bmu_ap             = r_ap;
  assign o_bmu_a_in           = r_a;
  assign o_bmu_b_in           = r_b;
  assign o_bmu_csr_ren_in     = r_csr_ren;
  assign o_bmu_csr_rddata_in  = r_csr_rddata;

`ifdef BMU_ARB_PERF_EN
  logic [NREQ-1:0][15:0] r_perf_grant;
  logic [15:0]           r_perf_err;

  // Saturating grant and error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_grant <= '0;
      r_perf_err   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_req_hs && (w_gnt == IDW'(i)) && (r_perf_grant[i] != 16'hFFFF)) begin
          r_perf_grant[i] <= r_perf_grant[i] + 16'd1;
        end
      end
      if (w_rsp_hs && r_rsp_error && (r_perf_err != 16'hFFFF)) begin
        r_perf_err <= r_perf_err + 16'd1;
      end
    end
  end

  assign o_perf_grant_cnt = r_perf_grant;
  assign o_perf_err_cnt   = r_perf_err;
`else
  assign o_perf_grant_cnt = '0;
  assign o_perf_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_bmu_req_arb.sv
// Directed bench for bmu_req_arb (NREQ=2, BMU_LAT=1) with a small BMU model.
module tb_bmu_req_arb;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AP_W = 32;
  localparam int unsigned IDW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              scan_mode;
  logic              bmu_scan_mode;
  logic              bmu_valid_in;
  logic [AP_W-1:0]   bmu_ap;
  logic              bmu_csr_ren_in;
  logic [31:0]       bmu_csr_rddata_in;
  logic [31:0]       bmu_a_in;
  logic [31:0]       bmu_b_in;
  logic [31:0]       bmu_result_ff = '0;
  logic              bmu_error = 1'b0;
  logic [NREQ*16-1:0] perf_grant_cnt;
  logic [15:0]       perf_err_cnt;

  int n_checks = 0;
  int n_err    = 0;

  bmu_req_arb_if #(.NREQ(NREQ), .AP_W(AP_W), .IDW(IDW)) bus ();

  bmu_req_arb #(.NREQ(NREQ), .AP_W(AP_W), .BMU_LAT(1), .IDW(IDW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_scan_mode         (scan_mode),
    .bus                 (bus),
    .o_bmu_scan_mode     (bmu_scan_mode),
    .o_bmu_valid_in      (bmu_valid_in),
    .o_bmu_ap            (bmu_ap),
    .o_bmu_csr_ren_in    (bmu_csr_ren_in),
    .o_bmu_csr_rddata_in (bmu_csr_rddata_in),
    .o_bmu_a_in          (bmu_a_in),
    .o_bmu_b_in          (bmu_b_in),
    .i_bmu_result_ff     (bmu_result_ff),
    .i_bmu_error         (bmu_error),
    .o_perf_grant_cnt    (perf_grant_cnt),
    .o_perf_err_cnt      (perf_err_cnt)
  );

  always #5 clk = ~clk;

  // BMU model, latency 1: ap[2]=error, ap[1]=AND, ap[0]=OR, else XOR.
  always @(posedge clk) begin
    if (bmu_valid_in) begin
      if (bmu_ap[2]) begin
        bmu_result_ff <= 32'hDEAD_BEEF;
        bmu_error     <= 1'b1;
      end else if (bmu_ap[1]) begin
        bmu_result_ff <= bmu_a_in & bmu_b_in;
        bmu_error     <= 1'b0;
      end else if (bmu_ap[0]) begin
        bmu_result_ff <= bmu_a_in | bmu_b_in;
        bmu_error     <= 1'b0;
      end else begin
        bmu_result_ff <= bmu_a_in ^ bmu_b_in;
        bmu_error     <= 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef BMU_ARB_PERF_EN
  localparam logic [31:0] EXP_GRANT = 32'h0002_0002;
  localparam logic [15:0] EXP_ERR   = 16'd1;
`else
  localparam logic [31:0] EXP_GRANT = 32'h0;
  localparam logic [15:0] EXP_ERR   = 16'd0;
`endif

  initial begin
    rst                = 1'b1;
    scan_mode          = 1'b1;
    bus.req_valid      = '0;
    bus.req_ap         = '0;
    bus.req_a          = '0;
    bus.req_b          = '0;
    bus.req_csr_ren    = '0;
    bus.req_csr_rddata = '0;
    bus.rsp_ready      = 1'b0;

    // Reset with all requests valid
    bus.req_valid = 2'b11;
    step(); step(); step();
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_bmu_valid", 64'(bmu_valid_in), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_rsp_result", 64'(bus.rsp_result), 64'h0);
    chk("rst_bmu_a", 64'(bmu_a_in), 64'h0);
    chk("rst_perf_grant", 64'(perf_grant_cnt), 64'h0);
    chk("rst_perf_err", 64'(perf_err_cnt), 64'h0);
    chk("scan_pass_1", 64'(bmu_scan_mode), 64'h1);
    scan_mode = 1'b0;
    #1;
    chk("scan_pass_0", 64'(bmu_scan_mode), 64'h0);
    bus.req_valid = 2'b00;
    rst = 1'b0;

    // Single OR op from requester 0 (also carries CSR fields)
    bus.req_ap[31:0]          = 32'h1;
    bus.req_a[31:0]           = 32'h0000_00F0;
    bus.req_b[31:0]           = 32'h0000_000F;
    bus.req_csr_ren[0]        = 1'b1;
    bus.req_csr_rddata[31:0]  = 32'h1234_5678;
    bus.req_valid             = 2'b01;
    #1;
    chk("single_ready", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = 2'b00;
    chk("single_issue_valid", 64'(bmu_valid_in), 64'h1);
    chk("single_issue_a", 64'(bmu_a_in), 64'h0000_00F0);
    chk("single_issue_b", 64'(bmu_b_in), 64'h0000_000F);
    chk("single_issue_ap", 64'(bmu_ap), 64'h1);
    chk("single_issue_csr_ren", 64'(bmu_csr_ren_in), 64'h1);
    chk("single_issue_csr_data", 64'(bmu_csr_rddata_in), 64'h1234_5678);
    chk("single_issue_ready", 64'(bus.req_ready), 64'h0);
    step();
    chk("single_wait_valid", 64'(bmu_valid_in), 64'h0);
    chk("single_wait_rsp", 64'(bus.rsp_valid), 64'h0);
    step();
    chk("single_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("single_rsp_id", 64'(bus.rsp_id), 64'h0);
    chk("single_rsp_result", 64'(bus.rsp_result), 64'h0000_00FF);
    chk("single_rsp_error", 64'(bus.rsp_error), 64'h0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("single_idle_rsp", 64'(bus.rsp_valid), 64'h0);
    chk("single_hold_a", 64'(bmu_a_in), 64'h0000_00F0);

    // Fresh reset so fairness starts from ptr=0 with cleared counters
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Fairness: both valid, rsp_ready high, expect 0,1,0,1
    bus.req_ap[63:32] = 32'h2;
    bus.req_a[63:32]  = 32'hFF00_FF00;
    bus.req_b[63:32]  = 32'h0FF0_0FF0;
    bus.req_valid     = 2'b11;
    bus.rsp_ready     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #0;
      chk($sformatf("fair_ready_%0d", k), 64'(bus.req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      step(); step(); step();
      chk($sformatf("fair_id_%0d", k), 64'(bus.rsp_id), (k % 2 == 0) ? 64'h0 : 64'h1);
      chk($sformatf("fair_res_%0d", k), 64'(bus.rsp_result),
          (k % 2 == 0) ? 64'h0000_00FF : 64'h0F00_0F00);
      step();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    #1;
    chk("fair_perf_grant", 64'(perf_grant_cnt), 64'(EXP_GRANT));

    // Backpressure: ptr=0, both valid, rsp_ready low for 5 cycles
    bus.req_valid = 2'b11;
    #1;
    chk("bp_ready", 64'(bus.req_ready), 64'h1);
    step(); step(); step();
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp_valid_%0d", k), 64'(bus.rsp_valid), 64'h1);
      chk($sformatf("bp_result_%0d", k), 64'(bus.rsp_result), 64'h0000_00FF);
      chk($sformatf("bp_id_%0d", k), 64'(bus.rsp_id), 64'h0);
      chk($sformatf("bp_ready_%0d", k), 64'(bus.req_ready), 64'h0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp_after_rsp", 64'(bus.rsp_valid), 64'h0);
    chk("bp_accept_next", 64'(bus.req_ready), 64'h2);

    // Error op from requester 1 accepted in this cycle
    bus.req_ap[63:32] = 32'h4;
    bus.req_valid     = 2'b10;
    step();
    bus.req_valid = 2'b00;
    step(); step();
    chk("err_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("err_rsp_error", 64'(bus.rsp_error), 64'h1);
    chk("err_rsp_result", 64'(bus.rsp_result), 64'hDEAD_BEEF);
    chk("err_rsp_id", 64'(bus.rsp_id), 64'h1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("err_perf", 64'(perf_err_cnt), 64'(EXP_ERR));

    // Abort: move ptr to 1, start a requester-1 op, reset in WAIT
    bus.req_ap[63:32] = 32'h0;
    bus.req_a[63:32]  = 32'hAAAA_0000;
    bus.req_valid     = 2'b01;
    bus.rsp_ready     = 1'b1;
    step(); step(); step(); step();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("abort_grant_1", 64'(bus.req_ready), 64'h2);
    step();
    chk("abort_issue_a", 64'(bmu_a_in), 64'hAAAA_0000);
    step();
    rst = 1'b1;
    step();
    chk("abort_bmu_valid", 64'(bmu_valid_in), 64'h0);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("abort_ready_in_rst", 64'(bus.req_ready), 64'h0);
    rst = 1'b0;
    #1;
    chk("abort_ptr0_grant", 64'(bus.req_ready), 64'h1);
    step();
    bus.req_valid = 2'b00;
    chk("abort_reissue_valid", 64'(bmu_valid_in), 64'h1);
    chk("abort_reissue_a", 64'(bmu_a_in), 64'h0000_00F0);
    chk("abort_no_rsp", 64'(bus.rsp_valid), 64'h0);
    step(); step();
    chk("abort_final_rsp_id", 64'(bus.rsp_id), 64'h0);
    chk("abort_final_result", 64'(bus.rsp_result), 64'h0000_00FF);
    chk("abort_perf_err_clr", 64'(perf_err_cnt), 64'h0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
